mc_core_arbiter: RTL and testbench



---
 rtl/phold_mc_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/mc_core_arbiter.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mc_core_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phold_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phold_mc_pkg
//  Description : Shared MC-interface definitions for the phold personality.
//                MC command encodings (request and response), MC size
//                encodings and helper functions that locate the core-ID
//                field inside rtnctl.
//  Revision    : 1.0  initial release
// ============================================================================
package phold_mc_pkg;

    // Request commands
    localparam logic [2:0] MC_CMD_RD      = 3'd1;
    localparam logic [2:0] MC_CMD_WR      = 3'd2;
    // Response commands
    localparam logic [2:0] MC_CMD_RD_DATA = 3'd2;
    localparam logic [2:0] MC_CMD_WR_CMP  = 3'd3;

    // Access size encodings
    localparam logic [1:0] MC_SIZE_1B = 2'd0;
    localparam logic [1:0] MC_SIZE_2B = 2'd1;
    localparam logic [1:0] MC_SIZE_4B = 2'd2;
    localparam logic [1:0] MC_SIZE_8B = 2'd3;

    // rtnctl layout: {zeros, core_id, tag}; the tag sits at bit 0.
    function automatic int rtnctl_core_lsb(input int tag_w);
        return tag_w;
    endfunction

    function automatic int rtnctl_core_msb(input int tag_w, input int core_w);
        return tag_w + core_w - 1;
    endfunction

endpackage : phold_mc_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first asserted
//                request found searching upward from ptr+1 with wrap-around.
//                N must be a power of two so the index add wraps naturally.
//  Ports       : req[N]  request vector
//                en      grant enable (no grant when low)
//                ptr     last granted index
//                gnt[N]  one-hot grant
//                idx     encoded grant index (0 when no grant)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    // k = N truncates to offset 0, so ptr itself is examined last.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = ptr + IW'(k);
            if (en && !w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mc_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mc_core_arbiter
//  Description : Shares one MC port among NUM_CORES phold cores. Round-robin
//                grant into a single registered request slot, rtnctl tagging
//                with {core, tag}, registered response routing and per-core
//                credit counters limiting outstanding requests to MAX_OUTST.
//  Ports       : clk, rst_n (async active-low)
//                core_rq_*  per-core packed request buses, core_rq_gnt out
//                core_rs_*  routed response (one-hot vld)
//                mc_rq_*    MC request slot, mc_rq_stall backpressure in
//                mc_rs_*    MC response in; mc_rs_stall/mc_rq_flush tied 0
//                idle, err  status (err is sticky)
//  Options     : `define MC_ARB_STATS_EN adds stat_rq_total,
//                stat_stall_cycles and stat_credit_block counters.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_core_arbiter
    import phold_mc_pkg::*;
#(
    parameter int NUM_CORES    = 8,
    parameter int RTNCTL_WIDTH = 32,
    parameter int TAG_W        = 8,
    parameter int MAX_OUTST    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORES-1:0]         core_rq_vld,
    input  logic [3*NUM_CORES-1:0]       core_rq_cmd,
    input  logic [4*NUM_CORES-1:0]       core_rq_scmd,
    input  logic [2*NUM_CORES-1:0]       core_rq_size,
    input  logic [48*NUM_CORES-1:0]      core_rq_vadr,
    input  logic [64*NUM_CORES-1:0]      core_rq_data,
    input  logic [TAG_W*NUM_CORES-1:0]   core_rq_tag,
    output logic [NUM_CORES-1:0]         core_rq_gnt,
    output logic [NUM_CORES-1:0]         core_rs_vld,
    output logic [2:0]                   core_rs_cmd,
    output logic [3:0]                   core_rs_scmd,
    output logic [TAG_W-1:0]             core_rs_tag,
    output logic [63:0]                  core_rs_data,
    output logic                         mc_rq_vld,
    output logic [2:0]                   mc_rq_cmd,
    output logic [3:0]                   mc_rq_scmd,
    output logic [1:0]                   mc_rq_size,
    output logic [47:0]                  mc_rq_vadr,
    output logic [63:0]                  mc_rq_data,
    output logic [RTNCTL_WIDTH-1:0]      mc_rq_rtnctl,
    input  logic                         mc_rq_stall,
    input  logic                         mc_rs_vld,
    input  logic [2:0]                   mc_rs_cmd,
    input  logic [3:0]                   mc_rs_scmd,
    input  logic [63:0]                  mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0]      mc_rs_rtnctl,
    output logic                         mc_rs_stall,
    output logic                         mc_rq_flush,
    output logic                         idle,
`ifdef MC_ARB_STATS_EN
    output logic [63:0]                  stat_rq_total,
    output logic [63:0]                  stat_stall_cycles,
    output logic [63:0]                  stat_credit_block,
`endif
    output logic                         err
);

    localparam int                C_CORE_W    = $clog2(NUM_CORES);
    localparam int                C_CNT_W     = $clog2(MAX_OUTST + 1);
    localparam int                C_CORE_LSB  = rtnctl_core_lsb(TAG_W);
    localparam int                C_ID_TOP    = rtnctl_core_msb(TAG_W, C_CORE_W) + 1;
    localparam logic [C_CNT_W-1:0]  C_MAX_OUTST = C_CNT_W'(MAX_OUTST);
    localparam logic [C_CORE_W-1:0] C_PTR_RST   = C_CORE_W'(NUM_CORES - 1);

    // ---------------- per-core views of the packed request buses ----------
    logic [2:0]       w_cmd  [NUM_CORES];
    logic [3:0]       w_scmd [NUM_CORES];
    logic [1:0]       w_size [NUM_CORES];
    logic [47:0]      w_vadr [NUM_CORES];
    logic [63:0]      w_data [NUM_CORES];
    logic [TAG_W-1:0] w_tag  [NUM_CORES];

    logic [C_CNT_W-1:0]  r_cnt [NUM_CORES];
    logic [NUM_CORES-1:0] w_elig;
    logic [NUM_CORES-1:0] w_full;
    logic [NUM_CORES-1:0] w_cnt_nz;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign w_cmd[g]    = core_rq_cmd[g*3 +: 3];
        assign w_scmd[g]   = core_rq_scmd[g*4 +: 4];
        assign w_size[g]   = core_rq_size[g*2 +: 2];
        assign w_vadr[g]   = core_rq_vadr[g*48 +: 48];
        assign w_data[g]   = core_rq_data[g*64 +: 64];
        assign w_tag[g]    = core_rq_tag[g*TAG_W +: TAG_W];
        // Registered count only: a response this cycle does not free a slot
        // until the next cycle.
        assign w_elig[g]   = core_rq_vld[g] && (r_cnt[g] < C_MAX_OUTST);
        assign w_full[g]   = (r_cnt[g] == C_MAX_OUTST);
        assign w_cnt_nz[g] = (r_cnt[g] != '0);
    end

    // ---------------- arbitration ----------------------------------------
    logic                  r_mc_rq_vld;
    logic [C_CORE_W-1:0]   r_ptr;
    logic                  w_out_free;
    logic [NUM_CORES-1:0]  w_gnt;
    logic [C_CORE_W-1:0]   w_gnt_idx;
    logic [RTNCTL_WIDTH-1:0] w_rtnctl;

    assign w_out_free = !r_mc_rq_vld || !mc_rq_stall;

    rr_arbiter #(
        .N   (NUM_CORES)
    ) u_rr_arbiter (
        .req (w_elig),
        .en  (w_out_free),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_gnt_idx)
    );

    always_comb begin
        w_rtnctl                             = '0;
        w_rtnctl[TAG_W-1:0]                  = w_tag[w_gnt_idx];
        w_rtnctl[C_CORE_LSB +: C_CORE_W]     = w_gnt_idx;
    end

    // ---------------- MC request slot -------------------------------------
    logic [2:0]              r_mc_rq_cmd;
    logic [3:0]              r_mc_rq_scmd;
    logic [1:0]              r_mc_rq_size;
    logic [47:0]             r_mc_rq_vadr;
    logic [63:0]             r_mc_rq_data;
    logic [RTNCTL_WIDTH-1:0] r_mc_rq_rtnctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mc_rq_vld    <= 1'b0;
            r_mc_rq_cmd    <= '0;
            r_mc_rq_scmd   <= '0;
            r_mc_rq_size   <= '0;
            r_mc_rq_vadr   <= '0;
            r_mc_rq_data   <= '0;
            r_mc_rq_rtnctl <= '0;
            r_ptr          <= C_PTR_RST;
        end else if (w_out_free) begin
            if (|w_gnt) begin
                r_mc_rq_vld    <= 1'b1;
                r_mc_rq_cmd    <= w_cmd[w_gnt_idx];
                r_mc_rq_scmd   <= w_scmd[w_gnt_idx];
                r_mc_rq_size   <= w_size[w_gnt_idx];
                r_mc_rq_vadr   <= w_vadr[w_gnt_idx];
                r_mc_rq_data   <= w_data[w_gnt_idx];
                r_mc_rq_rtnctl <= w_rtnctl;
                r_ptr          <= w_gnt_idx;
            end else begin
                r_mc_rq_vld    <= 1'b0;
            end
        end
    end

    // ---------------- response routing ------------------------------------
    logic                 w_rs_id_bad;
    logic                 w_rs_ok;
    logic [C_CORE_W-1:0]  w_rs_core;
    logic [NUM_CORES-1:0] w_rs_dec;
    logic [NUM_CORES-1:0] w_uf;

    // Any set bit above the core field means an ID >= NUM_CORES.
    if (C_ID_TOP < RTNCTL_WIDTH) begin : g_id_upper
        assign w_rs_id_bad = |mc_rs_rtnctl[RTNCTL_WIDTH-1:C_ID_TOP];
    end else begin : g_id_full
        assign w_rs_id_bad = 1'b0;
    end

    assign w_rs_core = mc_rs_rtnctl[C_CORE_LSB +: C_CORE_W];
    assign w_rs_ok   = mc_rs_vld && !w_rs_id_bad;

    always_comb begin
        w_rs_dec = '0;
        if (w_rs_ok) begin
            w_rs_dec[w_rs_core] = 1'b1;
        end
    end

    // A decrement at zero is an underflow unless a grant cancels it.
    always_comb begin
        w_uf = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_uf[i] = w_rs_dec[i] && !w_gnt[i] && !w_cnt_nz[i];
        end
    end

    logic [NUM_CORES-1:0] r_rs_vld;
    logic [2:0]           r_rs_cmd;
    logic [3:0]           r_rs_scmd;
    logic [TAG_W-1:0]     r_rs_tag;
    logic [63:0]          r_rs_data;
    logic                 r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_vld  <= '0;
            r_rs_cmd  <= '0;
            r_rs_scmd <= '0;
            r_rs_tag  <= '0;
            r_rs_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rs_vld <= w_rs_dec;
            if (w_rs_ok) begin
                r_rs_cmd  <= mc_rs_cmd;
                r_rs_scmd <= mc_rs_scmd;
                r_rs_tag  <= mc_rs_rtnctl[TAG_W-1:0];
                r_rs_data <= mc_rs_data;
            end
            r_err <= r_err | (mc_rs_vld && w_rs_id_bad) | (|w_uf);
        end
    end

    // ---------------- credit counters -------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_gnt[i] && !w_rs_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + C_CNT_W'(1);
                end else if (!w_gnt[i] && w_rs_dec[i] && w_cnt_nz[i]) begin
                    r_cnt[i] <= r_cnt[i] - C_CNT_W'(1);
                end
            end
        end
    end

`ifdef MC_ARB_STATS_EN
    // ---------------- statistics (saturating) -----------------------------
    logic [63:0] r_stat_rq_total;
    logic [63:0] r_stat_stall_cycles;
    logic [63:0] r_stat_credit_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rq_total     <= '0;
            r_stat_stall_cycles <= '0;
            r_stat_credit_block <= '0;
        end else begin
            if (r_mc_rq_vld && !mc_rq_stall && (r_stat_rq_total != '1)) begin
                r_stat_rq_total <= r_stat_rq_total + 64'd1;
            end
            if (r_mc_rq_vld && mc_rq_stall && (r_stat_stall_cycles != '1)) begin
                r_stat_stall_cycles <= r_stat_stall_cycles + 64'd1;
            end
            if ((|(core_rq_vld & w_full)) && (r_stat_credit_block != '1)) begin
                r_stat_credit_block <= r_stat_credit_block + 64'd1;
            end
        end
    end

    assign stat_rq_total     = r_stat_rq_total;
    assign stat_stall_cycles = r_stat_stall_cycles;
    assign stat_credit_block = r_stat_credit_block;
`else
    logic w_unused_full;
    assign w_unused_full = |w_full;
`endif

    // ---------------- outputs ---------------------------------------------
    assign core_rq_gnt  = w_gnt;
    assign core_rs_vld  = r_rs_vld;
    assign core_rs_cmd  = r_rs_cmd;
    assign core_rs_scmd = r_rs_scmd;
    assign core_rs_tag  = r_rs_tag;
    assign core_rs_data = r_rs_data;
    assign mc_rq_vld    = r_mc_rq_vld;
    assign mc_rq_cmd    = r_mc_rq_cmd;
    assign mc_rq_scmd   = r_mc_rq_scmd;
    assign mc_rq_size   = r_mc_rq_size;
    assign mc_rq_vadr   = r_mc_rq_vadr;
    assign mc_rq_data   = r_mc_rq_data;
    assign mc_rq_rtnctl = r_mc_rq_rtnctl;
    assign mc_rs_stall  = 1'b0;
    assign mc_rq_flush  = 1'b0;
    assign idle         = !r_mc_rq_vld && !(|w_cnt_nz);
    assign err          = r_err;

endmodule : mc_core_arbiter
`default_nettype wire

// File: tb/tb_mc_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_core_arbiter
//  Description : Scoreboard bench for mc_core_arbiter (default parameters).
//                Stimulus pushes expected MC transfers and core responses into
//                queues; a negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_core_arbiter;
    import phold_mc_pkg::*;

    localparam int NC = 8;
    localparam int TW = 8;
    localparam int RW = 32;

    typedef struct {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [1:0]  size;
        logic [47:0] vadr;
        logic [63:0] data;
        logic [31:0] rtnctl;
    } rq_t;

    typedef struct {
        logic [7:0]  vld;
        logic [2:0]  cmd;
        logic [7:0]  tag;
        logic [63:0] data;
    } rs_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NC-1:0]      core_rq_vld;
    logic [3*NC-1:0]    core_rq_cmd;
    logic [4*NC-1:0]    core_rq_scmd;
    logic [2*NC-1:0]    core_rq_size;
    logic [48*NC-1:0]   core_rq_vadr;
    logic [64*NC-1:0]   core_rq_data;
    logic [TW*NC-1:0]   core_rq_tag;
    logic [NC-1:0]      core_rq_gnt;
    logic [NC-1:0]      core_rs_vld;
    logic [2:0]         core_rs_cmd;
    logic [3:0]         core_rs_scmd;
    logic [TW-1:0]      core_rs_tag;
    logic [63:0]        core_rs_data;
    logic               mc_rq_vld;
    logic [2:0]         mc_rq_cmd;
    logic [3:0]         mc_rq_scmd;
    logic [1:0]         mc_rq_size;
    logic [47:0]        mc_rq_vadr;
    logic [63:0]        mc_rq_data;
    logic [RW-1:0]      mc_rq_rtnctl;
    logic               mc_rq_stall;
    logic               mc_rs_vld;
    logic [2:0]         mc_rs_cmd;
    logic [3:0]         mc_rs_scmd;
    logic [63:0]        mc_rs_data;
    logic [RW-1:0]      mc_rs_rtnctl;
    logic               mc_rs_stall;
    logic               mc_rq_flush;
    logic               idle;
    logic               err;
`ifdef MC_ARB_STATS_EN
    logic [63:0]        stat_rq_total;
    logic [63:0]        stat_stall_cycles;
    logic [63:0]        stat_credit_block;
`endif

    mc_core_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_rq_vld  (core_rq_vld),
        .core_rq_cmd  (core_rq_cmd),
        .core_rq_scmd (core_rq_scmd),
        .core_rq_size (core_rq_size),
        .core_rq_vadr (core_rq_vadr),
        .core_rq_data (core_rq_data),
        .core_rq_tag  (core_rq_tag),
        .core_rq_gnt  (core_rq_gnt),
        .core_rs_vld  (core_rs_vld),
        .core_rs_cmd  (core_rs_cmd),
        .core_rs_scmd (core_rs_scmd),
        .core_rs_tag  (core_rs_tag),
        .core_rs_data (core_rs_data),
        .mc_rq_vld    (mc_rq_vld),
        .mc_rq_cmd    (mc_rq_cmd),
        .mc_rq_scmd   (mc_rq_scmd),
        .mc_rq_size   (mc_rq_size),
        .mc_rq_vadr   (mc_rq_vadr),
        .mc_rq_data   (mc_rq_data),
        .mc_rq_rtnctl (mc_rq_rtnctl),
        .mc_rq_stall  (mc_rq_stall),
        .mc_rs_vld    (mc_rs_vld),
        .mc_rs_cmd    (mc_rs_cmd),
        .mc_rs_scmd   (mc_rs_scmd),
        .mc_rs_data   (mc_rs_data),
        .mc_rs_rtnctl (mc_rs_rtnctl),
        .mc_rs_stall  (mc_rs_stall),
        .mc_rq_flush  (mc_rq_flush),
        .idle         (idle),
`ifdef MC_ARB_STATS_EN
        .stat_rq_total     (stat_rq_total),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_credit_block (stat_credit_block),
`endif
        .err          (err)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    rq_t rq_q[$];
    rs_t rs_q[$];

    // Stimulus bookkeeping: what each core is currently driving.
    logic [2:0] drv_cmd [NC];
    logic [7:0] drv_tag [NC];

    function automatic logic [47:0] vadr_of(input int c);
        return 48'h0000_AB00_0000 | (48'(c) << 12);
    endfunction

    function automatic logic [63:0] data_of(input int c);
        return 64'hC0DE_0000_0000_0000 | 64'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input int c, input logic [2:0] cmd, input logic [7:0] tag);
        drv_cmd[c] = cmd;
        drv_tag[c] = tag;
        core_rq_cmd[c*3 +: 3]   = cmd;
        core_rq_scmd[c*4 +: 4]  = 4'h0;
        core_rq_size[c*2 +: 2]  = MC_SIZE_8B;
        core_rq_vadr[c*48 +: 48] = vadr_of(c);
        core_rq_data[c*64 +: 64] = data_of(c);
        core_rq_tag[c*8 +: 8]   = tag;
    endtask

    // Expected MC request for a grant to core c with what it drives now.
    task automatic push_rq(input int c);
        rq_t e;
        e.cmd    = drv_cmd[c];
        e.scmd   = 4'h0;
        e.size   = MC_SIZE_8B;
        e.vadr   = vadr_of(c);
        e.data   = data_of(c);
        e.rtnctl = (32'(c) << 8) | 32'(drv_tag[c]);
        rq_q.push_back(e);
    endtask

    task automatic set_rsp(input logic [31:0] rtn, input logic [2:0] cmd,
                           input logic [63:0] data, input logic [7:0] exp_vld);
        rs_t e;
        mc_rs_vld    = 1'b1;
        mc_rs_cmd    = cmd;
        mc_rs_scmd   = 4'h0;
        mc_rs_data   = data;
        mc_rs_rtnctl = rtn;
        if (exp_vld != 8'h00) begin
            e.vld  = exp_vld;
            e.cmd  = cmd;
            e.tag  = rtn[7:0];
            e.data = data;
            rs_q.push_back(e);
        end
    endtask

    task automatic send_rsp(input logic [31:0] rtn, input logic [2:0] cmd,
                            input logic [63:0] data, input logic [7:0] exp_vld);
        set_rsp(rtn, cmd, data, exp_vld);
        tick();
        mc_rs_vld = 1'b0;
    endtask

    // ---------------- monitor ---------------------------------------------
    rq_t m_rq;
    rs_t m_rs;
    always @(negedge clk) begin
        if (rst_n && mc_rq_vld && !mc_rq_stall) begin
            n_checks++;
            if (rq_q.size() == 0) begin
                n_errors++;
                $display("FAIL mc_rq_unexpected: got rtnctl=%0h expected no transfer", mc_rq_rtnctl);
            end else begin
                m_rq = rq_q.pop_front();
                if (mc_rq_cmd !== m_rq.cmd || mc_rq_scmd !== m_rq.scmd || mc_rq_size !== m_rq.size ||
                    mc_rq_vadr !== m_rq.vadr || mc_rq_data !== m_rq.data || mc_rq_rtnctl !== m_rq.rtnctl) begin
                    n_errors++;
                    $display("FAIL mc_rq: got cmd=%0h vadr=%0h data=%0h rtnctl=%0h expected cmd=%0h vadr=%0h data=%0h rtnctl=%0h",
                             mc_rq_cmd, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
                             m_rq.cmd, m_rq.vadr, m_rq.data, m_rq.rtnctl);
                end
            end
        end
        if (rst_n && (|core_rs_vld)) begin
            n_checks++;
            if (rs_q.size() == 0) begin
                n_errors++;
                $display("FAIL core_rs_unexpected: got vld=%0h expected none", core_rs_vld);
            end else begin
                m_rs = rs_q.pop_front();
                if (core_rs_vld !== m_rs.vld || core_rs_cmd !== m_rs.cmd ||
                    core_rs_tag !== m_rs.tag || core_rs_data !== m_rs.data || core_rs_scmd !== 4'h0) begin
                    n_errors++;
                    $display("FAIL core_rs: got vld=%0h cmd=%0h tag=%0h data=%0h expected vld=%0h cmd=%0h tag=%0h data=%0h",
                             core_rs_vld, core_rs_cmd, core_rs_tag, core_rs_data,
                             m_rs.vld, m_rs.cmd, m_rs.tag, m_rs.data);
                end
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    int ord[6] = '{0, 3, 5, 0, 3, 5};

    initial begin
        core_rq_vld = '0; core_rq_cmd = '0; core_rq_scmd = '0; core_rq_size = '0;
        core_rq_vadr = '0; core_rq_data = '0; core_rq_tag = '0;
        mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0;
        mc_rs_data = '0; mc_rs_rtnctl = '0;
        for (int c = 0; c < NC; c++) drive_core(c, MC_CMD_RD, 8'h10 + 8'(c));

        #2 rst_n = 1'b0;
        tick();
        chk("rst_mc_rq_vld", 64'(mc_rq_vld), 64'd0);
        chk("rst_rtnctl", 64'(mc_rq_rtnctl), 64'd0);
        chk("rst_core_rs_vld", 64'(core_rs_vld), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_rs_stall", 64'(mc_rs_stall), 64'd0);
        chk("rst_rq_flush", 64'(mc_rq_flush), 64'd0);
        rst_n = 1'b1;
        tick();

        // Round-robin among cores 0, 3, 5
        core_rq_vld = 8'b0010_1001;
        for (int n = 0; n < 6; n++) begin
            #1 chk("rr_gnt", 64'(core_rq_gnt), 64'(8'(1 << ord[n])));
            push_rq(ord[n]);
            tick();
        end
        core_rq_vld = '0;
        tick(); tick();
        for (int n = 0; n < 6; n++)
            send_rsp((32'(ord[n]) << 8) | 32'h33, MC_CMD_RD_DATA, 64'h1111_0000 + 64'(n), 8'(1 << ord[n]));
        tick();
        #1 chk("rr_idle_after", 64'(idle), 64'd1);
        chk("rr_err_after", 64'(err), 64'd0);

        // Stall hold on core 2
        drive_core(2, MC_CMD_WR, 8'h5C);
        mc_rq_stall = 1'b1;
        core_rq_vld = 8'h04;
        #1 chk("stall_first_gnt", 64'(core_rq_gnt), 64'h04);
        push_rq(2);
        tick();
        repeat (10) begin
            #1 chk("stall_no_gnt", 64'(core_rq_gnt), 64'h00);
            chk("stall_vld_hold", 64'(mc_rq_vld), 64'd1);
            chk("stall_rtnctl_hold", 64'(mc_rq_rtnctl), 64'h0000_025C);
            tick();
        end
        mc_rq_stall = 1'b0;
        #1 chk("stall_release_gnt", 64'(core_rq_gnt), 64'h04);
        push_rq(2);
        tick();
        core_rq_vld = '0;
        tick(); tick();
        send_rsp(32'h0000_025C, MC_CMD_WR_CMP, 64'h0, 8'h04);
        send_rsp(32'h0000_025C, MC_CMD_WR_CMP, 64'h0, 8'h04);

        // Credit limit on core 1
        core_rq_vld = 8'h02;
        for (int n = 0; n < 16; n++) begin
            drive_core(1, MC_CMD_RD, 8'(n));
            #1 chk("credit_gnt", 64'(core_rq_gnt), 64'h02);
            push_rq(1);
            tick();
        end
        #1 chk("credit_block", 64'(core_rq_gnt), 64'h00);
        chk("credit_not_idle", 64'(idle), 64'd0);
        tick();
        set_rsp(32'h0000_01A5, MC_CMD_RD_DATA, 64'hA5A5_0001, 8'h02);
        #1 chk("credit_block_rsp_cycle", 64'(core_rq_gnt), 64'h00);
        tick();
        mc_rs_vld = 1'b0;
        drive_core(1, MC_CMD_RD, 8'h77);
        #1 chk("credit_resume", 64'(core_rq_gnt), 64'h02);
        push_rq(1);
        tick();
        core_rq_vld = '0;
        tick(); tick();
        for (int n = 0; n < 16; n++)
            send_rsp(32'h0000_0100 | 32'(n), MC_CMD_RD_DATA, 64'h2222_0000 + 64'(n), 8'h02);

        // Simultaneous grant and response on core 4 at cnt = 5
        core_rq_vld = 8'h10;
        for (int n = 0; n < 5; n++) begin
            #1 chk("same_pre_gnt", 64'(core_rq_gnt), 64'h10);
            push_rq(4);
            tick();
        end
        set_rsp(32'h0000_0444, MC_CMD_RD_DATA, 64'h4444, 8'h10);
        #1 chk("same_cycle_gnt", 64'(core_rq_gnt), 64'h10);
        push_rq(4);
        tick();
        mc_rs_vld = 1'b0;
        core_rq_vld = '0;
        tick(); tick();
        for (int n = 0; n < 4; n++)
            send_rsp(32'h0000_0440 | 32'(n), MC_CMD_RD_DATA, 64'h4400 + 64'(n), 8'h10);
        tick();
        #1 chk("same_cnt_one_left", 64'(idle), 64'd0);
        send_rsp(32'h0000_0449, MC_CMD_RD_DATA, 64'h4409, 8'h10);
        tick();
        #1 chk("same_cnt_drained", 64'(idle), 64'd1);
        chk("same_no_underflow", 64'(err), 64'd0);

        // Out-of-range core ID
        send_rsp(32'h0000_08A5, MC_CMD_RD_DATA, 64'hBAD, 8'h00);
        tick();
        #1 chk("bad_id_err", 64'(err), 64'd1);
        repeat (3) tick();
        #1 chk("bad_id_err_sticky", 64'(err), 64'd1);

        // Reset with requests outstanding and one staged
        core_rq_vld = 8'h40;
        for (int n = 0; n < 3; n++) begin
            #1 chk("abort_gnt", 64'(core_rq_gnt), 64'h40);
            if (n < 2) push_rq(6);
            tick();
        end
        core_rq_vld = '0;
        mc_rq_stall = 1'b1;
        #1 chk("abort_staged", 64'(mc_rq_vld), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("abort_mc_rq_vld", 64'(mc_rq_vld), 64'd0);
        chk("abort_rtnctl", 64'(mc_rq_rtnctl), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        chk("abort_idle", 64'(idle), 64'd1);
        tick();
        mc_rq_stall = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        #1 chk("abort_idle_after", 64'(idle), 64'd1);
        chk("abort_err_after", 64'(err), 64'd0);
        send_rsp(32'h0000_0602, MC_CMD_RD_DATA, 64'h6602, 8'h40);
        tick();
        #1 chk("abort_underflow_err", 64'(err), 64'd1);

        repeat (3) tick();
        chk("rq_queue_drained", 64'(rq_q.size()), 64'd0);
        chk("rs_queue_drained", 64'(rs_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mc_core_arbiter
`default_nettype wire
